// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forward-select codes and the per-stage tag.
package hazard_ctrl_pkg;

  localparam int unsigned TAG_RA_W = 5;
  localparam int unsigned FWD_W    = 2;

  typedef logic [FWD_W-1:0] fwd_t;

  localparam fwd_t FWD_RF    = 2'b00;
  localparam fwd_t FWD_EXMEM = 2'b01;
  localparam fwd_t FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic [TAG_RA_W-1:0] rd;
    logic                we;
    logic                load;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

  // A source matches a stage when it is really read and the stage really writes it.
  function automatic logic src_match(input logic valid, input logic used,
                                     input logic [TAG_RA_W-1:0] rs, input tag_t t);
    return valid && used && (rs != '0) && t.we && (t.rd == rs);
  endfunction

  // The youngest producer wins.
  function automatic fwd_t fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)  return FWD_EXMEM;
    if (mem_hit) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder/pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [RA_W-1:0] id_rd;
  logic            id_we;
  logic            id_load;
  logic            ex_redirect;
  logic            mem_wait;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             byp_rs1;
  logic             byp_rs2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_load,
           ex_redirect, mem_wait,
    output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, fwd_a, fwd_b,
           byp_rs1, byp_rs2, stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_load,
           ex_redirect, mem_wait,
    input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, fwd_a, fwd_b,
           byp_rs1, byp_rs2, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_tag.sv
// One pipeline stage's destination tag: loads on enable, clears to an empty tag on request.
module pipe_tag
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  tag_t d_i,
  output tag_t q_o
);

  tag_t tag_q;
  tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (en_i) tag_d = clr_i ? TAG_NONE : d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= TAG_NONE;
    else        tag_q <= tag_d;
  end

  assign q_o = tag_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority, EX forward selects, WB->ID bypass, counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  tag_t ex_q, mem_q, wb_q;
  tag_t id_tag;

  logic [TAG_RA_W-1:0] rs1, rs2, rd;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, rs1_wb, rs2_wb;
  logic lu_c;

  logic pc_en_c, ifid_en_c, ifid_flush_c, idex_flush_c, pipe_en_c;
  logic stall_inc_c, flush_inc_c;

  fwd_t fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign rs1 = TAG_RA_W'(bus.id_rs1);
  assign rs2 = TAG_RA_W'(bus.id_rs2);
  assign rd  = TAG_RA_W'(bus.id_rd);

  // x0 is never a producer, so an rd of zero enters EX as a non-writing tag.
  always_comb begin
    id_tag      = TAG_NONE;
    id_tag.rd   = rd;
    id_tag.we   = bus.id_we   & bus.id_valid & (rd != '0);
    id_tag.load = bus.id_load & bus.id_valid & (rd != '0);
  end

  assign rs1_ex  = src_match(bus.id_valid, bus.id_rs1_used, rs1, ex_q);
  assign rs2_ex  = src_match(bus.id_valid, bus.id_rs2_used, rs2, ex_q);
  assign rs1_mem = src_match(bus.id_valid, bus.id_rs1_used, rs1, mem_q);
  assign rs2_mem = src_match(bus.id_valid, bus.id_rs2_used, rs2, mem_q);
  assign rs1_wb  = src_match(bus.id_valid, bus.id_rs1_used, rs1, wb_q);
  assign rs2_wb  = src_match(bus.id_valid, bus.id_rs2_used, rs2, wb_q);

  assign lu_c = (rs1_ex | rs2_ex) & ex_q.load;

  // Priority: memory freeze, then redirect, then load-use stall.
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    pipe_en_c    = 1'b1;
    stall_inc_c  = 1'b0;
    flush_inc_c  = 1'b0;
    if (bus.mem_wait) begin
      pc_en_c   = 1'b0;
      ifid_en_c = 1'b0;
      pipe_en_c = 1'b0;
    end else if (bus.ex_redirect) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      flush_inc_c  = 1'b1;
    end else if (lu_c) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
      stall_inc_c  = 1'b1;
    end
  end

  pipe_tag u_ex_tag (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pipe_en_c),
    .clr_i(idex_flush_c),
    .d_i  (id_tag),
    .q_o  (ex_q)
  );

  pipe_tag u_mem_tag (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pipe_en_c),
    .clr_i(1'b0),
    .d_i  (ex_q),
    .q_o  (mem_q)
  );

  pipe_tag u_wb_tag (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (pipe_en_c),
    .clr_i(1'b0),
    .d_i  (mem_q),
    .q_o  (wb_q)
  );

  // Forward selects travel with the instruction into EX; counters saturate.
  always_comb begin
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pipe_en_c) begin
      fwd_a_d = idex_flush_c ? FWD_RF : fwd_sel(rs1_ex, rs1_mem);
      fwd_b_d = idex_flush_c ? FWD_RF : fwd_sel(rs2_ex, rs2_mem);
    end
    if (stall_inc_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc_c && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.ifid_en    = ifid_en_c;
  assign bus.ifid_flush = ifid_flush_c;
  assign bus.idex_flush = idex_flush_c;
  assign bus.pipe_en    = pipe_en_c;
  assign bus.fwd_a      = fwd_a_q;
  assign bus.fwd_b      = fwd_b_q;
  assign bus.byp_rs1    = rs1_wb;
  assign bus.byp_rs2    = rs2_wb;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32I 5-stage core. It tracks destination-register tags of instructions in EX, MEM and WB, and from them generates stall, bubble and flush controls for the IF/ID and ID/EX registers. It also produces registered forwarding selects for the EX operand muxes and a WB→ID bypass for the register file, which writes on the clock edge and reads combinationally. It sits beside the decoder and owns no datapath.

## Interface
Parameters:
- `RA_W`, 5, register address width
- `CNT_W`, 16, width of the performance counters

Ports (in/out, width, meaning):
- `clk`, in, 1, core clock
- `rst_n`, in, 1, asynchronous reset, active-low
- `id_valid`, in, 1, ID holds a valid instruction
- `id_rs1`, in, RA_W, ID source register 1
- `id_rs2`, in, RA_W, ID source register 2
- `id_rs1_used`, in, 1, ID instruction reads rs1
- `id_rs2_used`, in, 1, ID instruction reads rs2
- `id_rd`, in, RA_W, ID destination register
- `id_we`, in, 1, ID instruction writes rd
- `id_load`, in, 1, ID instruction is a load
- `ex_redirect`, in, 1, taken branch or jump resolved in EX
- `mem_wait`, in, 1, data memory not ready; freezes the pipe
- `pc_en`, out, 1, PC update enable
- `ifid_en`, out, 1, IF/ID load enable
- `ifid_flush`, out, 1, IF/ID clear to NOP
- `idex_flush`, out, 1, ID/EX clear to bubble
- `pipe_en`, out, 1, ID/EX, EX/MEM and MEM/WB load enable
- `fwd_a`, out, 2, EX operand A select, registered
- `fwd_b`, out, 2, EX operand B select, registered
- `byp_rs1`, out, 1, ID rs1 takes WB data instead of the register file
- `byp_rs2`, out, 1, ID rs2 takes WB data instead of the register file
- `stall_cnt`, out, CNT_W, load-use stalls counted
- `flush_cnt`, out, CNT_W, redirects counted

## Operation
- **Stage tags.** Each of EX, MEM and WB holds a tag {rd, we, load}. A tag with rd==0 is treated as we=0, because x0 is never a producer.
- **Match rule.** Source rsN matches stage S iff id_valid, rsN_used, rsN!=0, S.we and S.rd==rsN.
- **Load-use hazard.** `lu = match(rs1,EX)&EX.load | match(rs2,EX)&EX.load`.
- **Priority (highest first):**
  - `mem_wait`: pc_en=ifid_en=pipe_en=0. No flushes. All tags, fwd selects and counters hold.
  - `ex_redirect`: pc_en=1, ifid_flush=1, idex_flush=1. stall_cnt does not increment. flush_cnt += 1.
  - `lu`: pc_en=0, ifid_en=0, idex_flush=1. stall_cnt += 1.
  - Otherwise: all enables 1, no flushes.
- **Forward select encoding,** computed per operand from ID, registered into EX:
  - FWD_RF=00: no match.
  - FWD_EXMEM=01: match in EX (producer will be in MEM).
  - FWD_MEMWB=10: match in MEM, and not in EX.
  - The youngest producer wins.
- **WB bypass.** byp_rsN=match(rsN,WB). This is combinational and covers the same-edge register-file write.
- **Counters** saturate at all-ones and never wrap.

## Timing
- **Reset (rst_n low, asynchronous):**
  - All tags are cleared (we=0, load=0, rd=0).
  - fwd_a and fwd_b are 00.
  - stall_cnt and flush_cnt are 0.
  - Combinational outputs then evaluate to pc_en=ifid_en=pipe_en=1 and flushes/byp=0, provided ex_redirect=0 and mem_wait=0.
- **Tag advance** occurs at each posedge with pipe_en=1:
  - WB←MEM and MEM←EX.
  - EX←{id_rd,id_we&id_valid,id_load&id_valid}, or a zero tag if idex_flush.
  - fwd_a and fwd_b load the ID-computed selects, or 00 if idex_flush.
- **Load-use latency.** Exactly 1 bubble cycle. On the next cycle the load is in MEM and the consumer registers FWD_MEMWB.
- **Back-to-back ALU dependency.** Zero stall.
- **Simultaneous redirect and lu.** The redirect wins: the consumer is flushed and the stall is not counted.
- **Simultaneous mem_wait and redirect.** The redirect is ignored this cycle. ex_redirect must be held by EX, since EX is frozen.
- **Reset mid-stall.** Reset takes effect immediately with no pending bubble retained.
- **Counter enables** are the priority-qualified conditions and are sampled on the same edge.

## Structure
- Shared core package holds:
  - FWD_RF, FWD_EXMEM, FWD_MEMWB constants.
  - The stage-tag struct/field widths, tied to RA_W=5.
- One sub-module: `pipe_tag`, a single-stage tag register with enable, clear and async active-low reset. It is instantiated three times, for EX, MEM and WB.
- Matching, priority and counters live in the `hazard_ctrl` top.

## Test plan
- **Reset.** Assert rst_n=0 mid-run. Required: fwd_a=fwd_b=00, counters 0. After release with idle inputs: pc_en=1, all flushes 0.
- **ALU chain.** Sequence: `add x5` (we=1), then `sub rs1=x5`, then `or rs2=x5`. Required:
  - sub: fwd_a=01 in EX.
  - or: fwd_b=10.
  - No stalls; stall_cnt=0.
- **Load-use.** `lw x7` followed by `add rs2=x7`. Required:
  - One cycle with pc_en=0, ifid_en=0, idex_flush=1.
  - Next cycle the add enters EX with fwd_b=10.
  - stall_cnt=1.
- **WB bypass and x0.** Producer of x9 in WB while ID reads rs1=x9: byp_rs1=1. A producer with rd=x0: no match, fwd=00, byp=0.
- **Redirect over load-use.** Load in EX, dependent instruction in ID, ex_redirect=1. Required:
  - ifid_flush=idex_flush=1, pc_en=1.
  - flush_cnt=1, stall_cnt unchanged.
- **mem_wait freeze.** Hold mem_wait=1 for 3 cycles with a pending forward. Required: pipe_en=0 and tags/fwd unchanged for those 3 cycles. After release, forwarding resolves as if there had been no wait.
